div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Parametrised multi-cycle radix-2 restoring divider that feeds the EX stage of the five-stage core.
- Handles MIPS DIV and DIVU. Result goes to HI/LO through the existing whilo/hi/lo path.
- While a divide is in flight, EX raises stallreq to ctrl.
- Generalises the fixed 32-bit divide: WIDTH is configurable, there is an annul (flush) input, divide-by-zero has an early-out, and a busy flag is exported.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived; not overridable).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; rst==0 sampled at a rising edge resets the block.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  input  WIDTH  dividend; sampled with start_i.
- opdata2_i  input  WIDTH  divisor; sampled with start_i.
- start_i  input  1  request; level-held by EX until ready_o is seen.
- annul_i  input  1  abort in-flight divide (pipeline flush).
- result_o  output  2*WIDTH  {remainder, quotient}: upper half goes to HI, lower half goes to LO.
- ready_o  output  1  result_o valid.
- busy_o  output  1  divide in progress (FREE excluded).

Behaviour:
- Reset (rst==0 at edge):
  - state=FREE, counter=0, result_o=0, ready_o=0, busy_o=0.
  - Reset has priority over every other input, in every state.
- States: FREE, BYZERO, ON, END. busy_o=1 in BYZERO, ON and END.
- FREE:
  - If start_i=1 and annul_i=0, latch the operands.
    - Divisor==0: go to BYZERO.
    - Otherwise: go to ON, with counter=0.
  - In signed mode, latch |dividend| and |divisor|. Also latch two sign flags: dividend sign, and dividend XOR divisor sign.
  - start_i with annul_i=1 is ignored.
- BYZERO: next edge goes to END with result_o=0 (quotient 0, remainder 0).
- ON:
  - Each edge performs one shift-subtract step on a (2*WIDTH+1)-bit partial remainder and increments counter.
  - The edge on which counter==WIDTH-1 performs the final step, then goes to END.
  - At that edge:
    - quotient is negated if the quotient-sign flag is set;
    - remainder is negated if the dividend was negative (signed mode only);
    - ready_o is set to 1.
- annul_i=1 in ON or BYZERO: next edge goes to FREE. ready_o stays 0, result_o=0, the partial result is discarded. annul has priority over step completion.
- END:
  - ready_o=1 and result_o is held stable.
  - While start_i=1, remain in END. A new start is not accepted until start_i has dropped.
  - When start_i=0, next edge goes to FREE with ready_o=0 and result_o=0.
  - annul_i in END also goes to FREE.
- Latency:
  - Nonzero divisor: ready_o is high after exactly WIDTH edges following the accepting edge.
  - Zero divisor: ready_o is high after 2 edges.
- Width and arithmetic rules:
  - Negation is two's complement modulo 2^WIDTH.
  - The most-negative dividend divided by -1 (signed) yields quotient = most-negative value (wrap) and remainder 0. No trap is raised.
- Operand inputs are don't-care outside the accepting edge; changing them mid-divide has no effect.

Test Plan:
- Reset mid-divide:
  - Stimulus: WIDTH=32; start DIVU 100/7; assert rst=0 at iteration 10.
  - Required: next cycle state=FREE, ready_o=0, busy_o=0, result_o=0. Also check that rst=0 asserted with no clock edge does not reset (synchronous).
- Unsigned latency:
  - Stimulus: DIVU 100/7.
  - Required: ready_o rises exactly 32 edges after the accepting edge with result_o={32'h2, 32'hE}. Hold start_i for 3 more cycles: result stable. Drop start_i: ready_o=0 next edge.
- Signed sign rules:
  - DIV -7/2 gives {FFFFFFFF, FFFFFFFD}.
  - DIV 7/-2 gives {00000001, FFFFFFFD}.
  - DIV 80000000/FFFFFFFF gives {00000000, 80000000}.
  - DIVU FFFFFFFF/2 gives {00000001, 7FFFFFFF}.
- Divide by zero:
  - Stimulus: DIV 1234/0.
  - Required: ready_o high after 2 edges, result_o=0, busy_o high for both cycles.
- Annul:
  - Stimulus: start DIVU 100/7; assert annul_i at iteration 5; hold start_i=1 through the next edge.
  - Required: FREE with ready_o never asserted. Also: start_i held high into END, then a new operand change while in END yields no restart and result unchanged.
- Parametrisation:
  - Stimulus: WIDTH=8, DIV 8'h81/8'h03 (-127/3).
  - Required: result_o={8'hFF, 8'hD6} (remainder -1, quotient -42), ready_o after 8 edges.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU to HI/LO).
// Produces one quotient bit per clock and also handles annul and a divide-by-zero early-out.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_neg_q;
   logic             r_neg_r;

   logic [WIDTH-1:0] w_abs1;
   logic [WIDTH-1:0] w_abs2;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fit;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_q_final;
   logic [WIDTH-1:0] w_r_final;

   assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // Remainder and quotient act as one (2*WIDTH+1)-bit partial remainder shifted left each step.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_dvsr};
   assign w_fit     = ~w_diff[WIDTH];
   assign w_rem_nxt = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};
   assign w_q_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
   assign w_r_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;

   assign busy_o = (r_state != S_FREE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_FREE;
         r_cnt    <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (r_state)
            S_FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  r_dvsr  <= w_abs2;
                  r_quo   <= w_abs1;
                  r_rem   <= '0;
                  r_neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  r_neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                  r_cnt   <= '0;
                  r_state <= (opdata2_i == '0) ? S_BYZERO : S_ON;
               end
            end
            S_BYZERO: begin
               result_o <= '0;
               if (annul_i) begin
                  ready_o <= 1'b0;
                  r_state <= S_FREE;
               end else begin
                  ready_o <= 1'b1;
                  r_state <= S_END;
               end
            end
            S_ON: begin
               if (annul_i) begin
                  ready_o  <= 1'b0;
                  result_o <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_FREE;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(WIDTH - 1)) begin
                     result_o <= {w_r_final, w_q_final};
                     ready_o  <= 1'b1;
                     r_state  <= S_END;
                  end
               end
            end
            S_END: begin
               // Hold the result until EX drops start, so a level-held request is not restarted.
               if (annul_i || !start_i) begin
                  ready_o  <= 1'b0;
                  result_o <= '0;
                  r_state  <= S_FREE;
               end
            end
            default: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               r_state  <= S_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases and randomized divides on a 32-bit and an 8-bit instance,
// checked against an arithmetic reference model.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        sg32, st32, an32, rdy32, bsy32;
   logic [31:0] a32, b32;
   logic [63:0] res32;
   logic        sg8, st8, an8, rdy8, bsy8;
   logic [7:0]  a8, b8;
   logic [15:0] res8;

   int n_checks = 0;
   int n_err    = 0;

   div_unit #(.WIDTH(32)) u_div32 (
      .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
      .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32), .busy_o(bsy32)
   );

   div_unit #(.WIDTH(8)) u_div8 (
      .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
      .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input bit w8, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (w8) begin
         sa = sgn ? longint'($signed(a[7:0])) : longint'({24'b0, a[7:0]});
         sb = sgn ? longint'($signed(b[7:0])) : longint'({24'b0, b[7:0]});
      end else begin
         sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
         sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      end
      if (sb == 0) return 64'b0;
      q = sa / sb;
      r = sa % sb;
      if (w8) return {48'b0, r[7:0], q[7:0]};
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [63:0] res(input bit w8);
      return w8 ? {48'b0, res8} : res32;
   endfunction
   function automatic logic rdy(input bit w8);
      return w8 ? rdy8 : rdy32;
   endfunction
   function automatic logic bsy(input bit w8);
      return w8 ? bsy8 : bsy32;
   endfunction

   task automatic drive(input bit w8, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit st);
      if (w8) begin
         sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; st8 = st;
      end else begin
         sg32 = sgn; a32 = a; b32 = b; st32 = st;
      end
   endtask

   // One complete divide: request, latency, result, optional hold in END, release.
   task automatic run(input string tag, input bit w8, input bit sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp, input int hold);
      int n;
      int lat;
      bit zero;
      zero = w8 ? (b[7:0] == 8'h0) : (b == 32'h0);
      lat  = zero ? 2 : (w8 ? 9 : 33);
      @(negedge clk);
      drive(w8, sgn, a, b, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         drive(w8, $urandom_range(0, 1) == 1, $urandom, $urandom, 1'b1);
         if (n == 1) chk({tag, " busy1"}, {63'b0, bsy(w8)}, 64'd1);
      end while (!rdy(w8) && n < 100);
      chk({tag, " latency"}, n, lat);
      chk({tag, " result"}, res(w8), exp);
      chk({tag, " busy_end"}, {63'b0, bsy(w8)}, 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         drive(w8, $urandom_range(0, 1) == 1, $urandom, $urandom, 1'b1);
         chk({tag, " hold_ready"}, {63'b0, rdy(w8)}, 64'd1);
         chk({tag, " hold_result"}, res(w8), exp);
      end
      drive(w8, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk({tag, " drop_ready"}, {63'b0, rdy(w8)}, 64'd0);
      chk({tag, " drop_busy"}, {63'b0, bsy(w8)}, 64'd0);
      chk({tag, " drop_result"}, res(w8), 64'd0);
   endtask

   initial begin
      logic        seen;
      logic [31:0] ra, rb;
      bit          rs;
      rst = 1'b0;
      an32 = 1'b0; an8 = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("reset32", {bsy32, rdy32, res32[61:0]}, 64'd0);
      chk("reset8", {46'b0, bsy8, rdy8, res8}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 3);
      run("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
      run("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0);
      run("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0);
      run("divu_max_2", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'h7FFFFFFF}, 0);
      run("div_by_zero", 1'b0, 1'b1, 32'd1234, 32'd0, 64'd0, 0);
      run("div8_m127_3", 1'b1, 1'b1, 32'h81, 32'h03, {48'b0, 8'hFF, 8'hD6}, 0);

      // Annul at iteration 5 with start still held.
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd100, 32'd7, 1'b1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= rdy32;
      end
      an32 = 1'b1;
      @(negedge clk);
      seen |= rdy32;
      chk("annul_busy", {63'b0, bsy32}, 64'd0);
      chk("annul_result", res32, 64'd0);
      @(negedge clk);
      seen |= rdy32;
      chk("annul_start_ignored", {63'b0, bsy32}, 64'd0);
      chk("annul_never_ready", {63'b0, seen}, 64'd0);
      an32 = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);

      // Synchronous reset at iteration 10.
      drive(1'b0, 1'b0, 32'd100, 32'd7, 1'b1);
      repeat (11) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_no_edge_busy", {63'b0, bsy32}, 64'd1);
      @(negedge clk);
      chk("rst_busy", {63'b0, bsy32}, 64'd0);
      chk("rst_ready", {63'b0, rdy32}, 64'd0);
      chk("rst_result", res32, 64'd0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         rs = $urandom_range(0, 1) == 1;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
         run("rand32", 1'b0, rs, ra, rb, model(1'b0, rs, ra, rb), 0);
      end
      for (int i = 0; i < 12; i++) begin
         rs = $urandom_range(0, 1) == 1;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         run("rand8", 1'b1, rs, ra, rb, model(1'b1, rs, ra, rb), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
